// File: rtl/rs_decoder_output_packer_if.sv
// Line write-back handshake between the RS output packer (master) and its consumer (slave).
interface rs_decoder_output_packer_if #(
    parameter int LINE_BYTES = 64
);
    logic                          line_valid;
    logic [8*LINE_BYTES-1:0]       line_data;
    logic [$clog2(LINE_BYTES):0]   line_bytes;
    logic                          line_ready;

    modport master (output line_valid, line_data, line_bytes, input line_ready);
    modport slave  (input line_valid, line_data, line_bytes, output line_ready);
endinterface

// File: rtl/rs_decoder_output_packer.sv
// Packs the RS decoder byte stream into cache lines and buffers them in a small line FIFO.
// Optional statistics counters are enabled by defining RS_DECODER_OUTPUT_PACKER_STATS_EN.
module rs_decoder_output_packer #(
    parameter int LINE_BYTES = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    input  logic        flush,
    rs_decoder_output_packer_if.master line_if,
    output logic        done,
    output logic        overflow,
`ifdef RS_DECODER_OUTPUT_PACKER_STATS_EN
    output logic [31:0] lines_pushed,
    output logic [31:0] lines_dropped,
    output logic [31:0] bytes_in,
`endif
    output logic        busy
);
    localparam int LW    = 8 * LINE_BYTES;
    localparam int BW    = $clog2(LINE_BYTES) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FLUSH, S_DRAIN} state_t;

    state_t             r_state, w_state_next;
    logic [LW-1:0]      r_line;
    logic [BW-1:0]      r_fill;
    logic [LW-1:0]      r_mem       [FIFO_DEPTH];
    logic [BW-1:0]      r_mem_bytes [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_overflow;

    logic [LW-1:0]      w_line_ins;
    logic               w_accept, w_line_done, w_flush_push, w_push, w_full, w_wr, w_pop;
    logic [LW-1:0]      w_push_data;
    logic [BW-1:0]      w_push_bytes;
    logic               w_done;
    logic               w_has;

    // Current line with the incoming byte dropped into slot r_fill.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_BYTES; gi++) begin : g_ins
            assign w_line_ins[8*gi +: 8] = (r_fill == BW'(gi)) ? data_in : r_line[8*gi +: 8];
        end
    endgenerate

    assign w_accept     = (r_state == S_COLLECT) && valid_in && !start;
    assign w_line_done  = w_accept && (r_fill == BW'(LINE_BYTES - 1));
    assign w_flush_push = (r_state == S_FLUSH) && (r_fill != '0) && !start;
    assign w_push       = w_line_done || w_flush_push;
    assign w_push_data  = w_line_done ? w_line_ins : r_line;
    assign w_push_bytes = w_line_done ? BW'(LINE_BYTES) : r_fill;
    // Full test uses the pre-pop count so a same-cycle pop never makes room.
    assign w_full       = (r_count == CW'(FIFO_DEPTH));
    assign w_wr         = w_push && !w_full;
    assign w_has        = (r_count != '0);
    assign w_pop        = w_has && line_if.line_ready && !start;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        if (start) begin
            w_state_next = S_COLLECT;
        end else begin
            case (r_state)
                S_IDLE:    w_state_next = S_IDLE;
                S_COLLECT: if (flush) w_state_next = S_FLUSH;
                S_FLUSH:   w_state_next = S_DRAIN;
                S_DRAIN: begin
                    if (!w_has) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
                default:   w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_line     <= '0;
            r_fill     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            // The assembly line is zeroed after every push so partial lines carry zero padding.
            if (w_line_done || r_state == S_FLUSH) begin
                r_line <= '0;
                r_fill <= '0;
            end else if (w_accept) begin
                r_line <= w_line_ins;
                r_fill <= r_fill + 1'b1;
            end
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && w_full) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_wr) begin
            r_mem[r_wr_ptr]       <= w_push_data;
            r_mem_bytes[r_wr_ptr] <= w_push_bytes;
        end
    end

    assign line_if.line_valid = w_has;
    assign line_if.line_data  = w_has ? r_mem[r_rd_ptr] : '0;
    assign line_if.line_bytes = w_has ? r_mem_bytes[r_rd_ptr] : '0;
    assign done     = w_done;
    assign overflow = r_overflow;
    assign busy     = (r_state != S_IDLE);

`ifdef RS_DECODER_OUTPUT_PACKER_STATS_EN
    logic [31:0] r_lines_pushed, r_lines_dropped, r_bytes_in;

    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_lines_pushed  <= '0;
            r_lines_dropped <= '0;
            r_bytes_in      <= '0;
        end else begin
            if (w_wr && r_lines_pushed != '1)              r_lines_pushed  <= r_lines_pushed + 1'b1;
            if (w_push && w_full && r_lines_dropped != '1) r_lines_dropped <= r_lines_dropped + 1'b1;
            if (w_accept && r_bytes_in != '1)              r_bytes_in      <= r_bytes_in + 1'b1;
        end
    end

    assign lines_pushed  = r_lines_pushed;
    assign lines_dropped = r_lines_dropped;
    assign bytes_in      = r_bytes_in;
`endif
endmodule

// File: doc/rs_decoder_output_packer.md
Name: rs_decoder_output_packer

Overview:
- Sink end of the Reed-Solomon decoder byte stream: takes the decoder's 8-bit data/valid output and packs it into 512-bit cache lines for write-back.
- Buffers completed lines in a small line FIFO. The FIFO is drained by the requestor's write path through a valid/ready handshake.
- Never overwrites a buffered line. On overflow it drops the new line and raises a sticky error.

Parameters:
- LINE_BYTES, 64, bytes per output line. line_data width = 8*LINE_BYTES.
- FIFO_DEPTH, 8, number of line entries. Must be a power of 2, >= 2.

Ports:
- clk  input  1  single clock for all state.
- reset  input  1  synchronous, active-high reset.
- start  input  1  pulse: begin a new job. Clears fill, FIFO, flags and counters.
- data_in  input  8  decoded byte from the decoder.
- valid_in  input  1  data_in valid. There is no backpressure; the byte must be accepted.
- flush  input  1  pulse: end of stream. Emit the partial line, then drain.
- line_valid  output  1  FIFO head is valid.
- line_data  output  8*LINE_BYTES  head line. Byte i is at bits [8i+7:8i].
- line_bytes  output  $clog2(LINE_BYTES)+1  number of valid bytes in the head line (1..LINE_BYTES).
- line_ready  input  1  consumer accepts the head. Transfer occurs when line_valid && line_ready.
- done  output  1  one-cycle pulse: flush completed and FIFO empty.
- overflow  output  1  sticky: at least one line was dropped.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, fill=0, FIFO empty.
  - line_valid=0, line_data=0, line_bytes=0, done=0, overflow=0, busy=0.
- States: IDLE, COLLECT, FLUSH, DRAIN.
  - IDLE: start -> COLLECT (clears everything). valid_in in IDLE is ignored.
  - COLLECT: each valid_in writes data_in to byte[fill] and increments fill.
    - When the byte makes fill reach LINE_BYTES, the line is pushed at that same clock edge with line_bytes=LINE_BYTES, and fill returns to 0.
    - flush -> FLUSH.
  - FLUSH (one cycle): if fill>0, push the partial line with unused bytes zeroed and line_bytes=fill, then set fill=0. Always -> DRAIN.
  - DRAIN: when FIFO is empty, pulse done for one cycle -> IDLE.
- Same-cycle valid_in and flush in COLLECT: the byte is included first, then flush applies. If that byte completes a line, the full line is pushed and FLUSH pushes nothing.
- start in any non-IDLE state: aborts the job. FIFO, fill and overflow are cleared, state -> COLLECT. start has priority over every other input.
- Latency: line_valid rises the cycle after the clock edge at which the completing byte (or FLUSH) is sampled.
- Output timing:
  - line_data and line_bytes are driven from FIFO storage and are stable while line_valid && !line_ready.
  - Throughput is 1 line/cycle when line_ready is held high.
- FIFO full when a push is due:
  - The line is dropped, overflow=1 (sticky until start or reset), and fill still returns to 0.
  - The head entry and stored entries are untouched.
  - A pop in the same cycle does not free space for that push; the full check uses the pre-pop count.
- Pointers wrap modulo FIFO_DEPTH. The count distinguishes full from empty.
- Bytes arriving during FLUSH or DRAIN are discarded.

Optional Feature:
- Macro: RS_DECODER_OUTPUT_PACKER_STATS_EN.
- When defined, adds outputs:
  - lines_pushed [31:0]: count of lines pushed.
  - lines_dropped [31:0]: count of lines dropped on overflow.
  - bytes_in [31:0]: count of accepted bytes.
- All three are zeroed on reset/start and saturate at all-ones.
- When not defined, the ports and counters do not exist. Core behaviour is identical either way.

Test Plan:
- Full line, consumer always ready: reset, start, 64 bytes 0x00..0x3F on consecutive cycles, line_ready=1.
  - Expect one transfer with line_data byte i = i and line_bytes=64, with line_valid 1 cycle after the 64th byte.
  - Then flush -> no extra line, done 2 cycles later.
- Partial flush: start, 10 bytes 0xA0..0xA9, flush.
  - Expect one line with bytes 0..9 = 0xA0..0xA9, bytes 10..63 = 0, line_bytes=10, then done.
- Overflow: FIFO_DEPTH=8, line_ready=0, 9*64 bytes.
  - Expect 8 lines held and overflow=1 after the 576th byte.
  - Then set line_ready=1: 8 lines pop intact (line 0 first byte pattern unchanged); the 9th line never appears.
- Simultaneous valid_in+flush on the 64th byte:
  - Exactly one line with line_bytes=64, no zero-length line, done asserted.
- Mid-job start: 3 full lines buffered with line_ready=0, plus 20 bytes partial, then start.
  - Next cycle line_valid=0, overflow=0, fill=0.
  - A following 64 bytes yield exactly one line.
- Backpressure stability: line_ready toggled randomly across 4 lines.
  - line_data/line_bytes hold while stalled, and lines emerge in order.
